cordic_pipe: RTL and testbench
==============================

CORDIC_PIPE -- requirements
Module: cordic_pipe

Interface
REQ-001 Parameter WIDTH, default 32: signed two's-complement width of x, y, z datapaths.
REQ-002 Parameter ITER, default 16: number of micro-rotation stages, 1..WIDTH-2.
REQ-003 Parameter FRAC, default 16: fractional bits of the angle format; angle value = radians * 2^FRAC.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ce  input  1  pipeline clock enable; 0 freezes every stage register including valids.
REQ-007 in_valid  input  1  sample on x_in/y_in/z_in/mode_in is accepted when in_valid=1 and ce=1.
REQ-008 mode_in  input  1  0 = rotation, 1 = vectoring; travels with its sample.
REQ-009 x_in, y_in, z_in  input  WIDTH each  signed operands.
REQ-010 out_valid  output  1  x_out/y_out/z_out/mode_out hold a completed result.
REQ-011 x_out, y_out, z_out  output  WIDTH each  signed results, registered.
REQ-012 mode_out  output  1  mode of the sample on the outputs.

Function
REQ-013 Pipeline shall be stage Q (quadrant pre-rotation), stages 0..ITER-1 (micro-rotations), then output register; latency ITER+2 ce-enabled cycles from acceptance to out_valid=1.
REQ-014 Throughput shall be one sample per ce-enabled cycle; no back-pressure, no internal stall other than ce.
REQ-015 Each stage shall carry its own valid and mode bits; stage registers load on every ce=1 cycle regardless of valid (bubbles propagate with valid=0).
REQ-016 Stage Q, rotation mode: z > round(pi/2*2^FRAC) -> (x,y,z) := (-y, x, z - pi/2); z < -pi/2 -> (y, -x, z + pi/2); else pass-through.
REQ-017 Stage Q, vectoring mode: x<0 and y>=0 -> (y, -x, z + pi/2); x<0 and y<0 -> (-y, x, z - pi/2); else pass-through.
REQ-018 Stage i direction: rotation d = +1 if z>=0 else -1; vectoring d = +1 if y<0 else -1.
REQ-019 Stage i update: x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan_i; >>> arithmetic, results truncated to WIDTH.
REQ-020 atan_i shall be round(atan(2^-i) * 2^FRAC), elaborated from parameters; for FRAC=16, atan_0=51472, atan_1=30386, atan_2=16055.
REQ-021 No gain compensation: magnitudes scaled by K = prod sqrt(1+2^-2i) (~1.64676 for ITER>=10).
REQ-022 Operand range: |x_in|,|y_in| <= 2^(WIDTH-3), |z_in| <= pi*2^FRAC; outside this range results are undefined but valid/mode timing shall be unaffected.
REQ-023 Rotation result: x_out ~ K(x cos z - y sin z), y_out ~ K(x sin z + y cos z), z_out ~ 0.
REQ-024 Vectoring result: x_out ~ K*sqrt(x^2+y^2), y_out ~ 0, z_out ~ z_in + atan2(y_in, x_in).
REQ-025 Modes may alternate on consecutive samples; each sample's result depends only on its own mode.
REQ-026 ce=0 while samples in flight: outputs and all stage contents hold; resuming ce=1 continues without loss or duplication.

Reset
REQ-027 rst_n=0 shall immediately clear every stage valid, out_valid and mode_out, and set x_out, y_out, z_out to 0, independent of clk and ce.
REQ-028 Samples in flight at reset assertion are discarded; the first out_valid after release corresponds to the first sample accepted after release.
REQ-029 Stage data registers other than outputs need not be reset.

Verification (WIDTH=32, ITER=16, FRAC=16, tolerance +/-8 LSB)
REQ-030 Rotation, x=39797, y=0, z=0 -> after 18 cycles out_valid=1, x_out~65536, y_out~0, z_out~0.
REQ-031 Rotation, x=39797, y=0, z=51472 -> x_out~46341, y_out~46341; z=154416 (3pi/4) -> x_out~-46341, y_out~46341 (pre-rotation path).
REQ-032 Vectoring, x=65536, y=65536, z=0 -> x_out~152625, y_out~0, z_out~51472; x=-65536, y=0 -> x_out~107922, z_out~205887.
REQ-033 Back-to-back 100 random samples, alternating modes, with in_valid and ce randomly deasserted -> outputs match reference model in order, one result per accepted sample, no extra out_valid.
REQ-034 rst_n pulsed low mid-stream with 10 samples in flight -> out_valid=0 and outputs 0 immediately; no stale result appears after release.
REQ-035 ce held 0 for 5 cycles with out_valid=1 -> outputs constant throughout; next result follows exactly one ce cycle after resume.

Source files
------------

// File: rtl/cordic_if.sv
// Sample/result bundle of the CORDIC pipeline: operands in, rotated or vectored results out.
// The master side presents operands; the slave side (the pipeline) returns results.
interface cordic_if #(
  parameter int WIDTH = 32
);
  logic                    in_valid;
  logic                    mode_in;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] z_in;
  logic                    out_valid;
  logic                    mode_out;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] z_out;

  modport master (
    output in_valid, mode_in, x_in, y_in, z_in,
    input  out_valid, mode_out, x_out, y_out, z_out
  );

  modport slave (
    input  in_valid, mode_in, x_in, y_in, z_in,
    output out_valid, mode_out, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC (rotation / vectoring), one sample per enabled clock, no gain compensation.
// Quadrant pre-rotation stage, ITER shift-add micro-rotation stages, then a registered output.
module cordic_pipe #(
  parameter int WIDTH = 32,
  parameter int ITER  = 16,
  parameter int FRAC  = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    ce,
  cordic_if.slave bus
);

  localparam real PI    = 3.14159265358979323846;
  localparam real SCALE = 2.0 ** FRAC;

  function automatic logic signed [WIDTH-1:0] round_fixed(input real r);
    return WIDTH'($rtoi((r < 0.0) ? (r - 0.5) : (r + 0.5)));
  endfunction

  localparam logic signed [WIDTH-1:0] HALF_PI     = round_fixed(PI / 2.0 * SCALE);
  localparam logic signed [WIDTH-1:0] NEG_HALF_PI = -HALF_PI;

  logic signed [WIDTH-1:0] x_q, y_q, z_q;
  logic signed [WIDTH-1:0] x_p0, y_p0, z_p0;
  logic                    mode_p0;
  logic                    vld_p0;

  logic signed [WIDTH-1:0] x_p1 [ITER];
  logic signed [WIDTH-1:0] y_p1 [ITER];
  logic signed [WIDTH-1:0] z_p1 [ITER];
  logic signed [WIDTH-1:0] x_nx [ITER];
  logic signed [WIDTH-1:0] y_nx [ITER];
  logic signed [WIDTH-1:0] z_nx [ITER];
  logic [ITER-1:0]         mode_p1;
  logic [ITER-1:0]         vld_p1;

  // Stage Q: fold the operand into the +/-pi/2 convergence range of the micro-rotations
  always_comb begin
    x_q = bus.x_in;
    y_q = bus.y_in;
    z_q = bus.z_in;
    if (!bus.mode_in) begin
      if (bus.z_in > HALF_PI) begin
        x_q = -bus.y_in;
        y_q = bus.x_in;
        z_q = bus.z_in - HALF_PI;
      end else if (bus.z_in < NEG_HALF_PI) begin
        x_q = bus.y_in;
        y_q = -bus.x_in;
        z_q = bus.z_in + HALF_PI;
      end
    end else if (bus.x_in[WIDTH-1]) begin
      if (!bus.y_in[WIDTH-1]) begin
        x_q = bus.y_in;
        y_q = -bus.x_in;
        z_q = bus.z_in + HALF_PI;
      end else begin
        x_q = -bus.y_in;
        y_q = bus.x_in;
        z_q = bus.z_in - HALF_PI;
      end
    end
  end

  // Stages 0..ITER-1: micro-rotation by +/-atan(2^-i), angle constants folded at elaboration
  for (genvar i = 0; i < ITER; i++) begin : g_stage
    localparam logic signed [WIDTH-1:0] ATAN = round_fixed($atan(1.0 / (2.0 ** i)) * SCALE);

    logic signed [WIDTH-1:0] xs, ys, zs;
    logic                    ms;
    logic                    pos;

    if (i == 0) begin : g_first
      assign xs = x_p0;
      assign ys = y_p0;
      assign zs = z_p0;
      assign ms = mode_p0;
    end else begin : g_chain
      assign xs = x_p1[i-1];
      assign ys = y_p1[i-1];
      assign zs = z_p1[i-1];
      assign ms = mode_p1[i-1];
    end

    // pos is d = +1: rotation drives z toward 0, vectoring drives y toward 0
    assign pos = ms ? ys[WIDTH-1] : ~zs[WIDTH-1];

    assign x_nx[i] = pos ? (xs - (ys >>> i)) : (xs + (ys >>> i));
    assign y_nx[i] = pos ? (ys + (xs >>> i)) : (ys - (xs >>> i));
    assign z_nx[i] = pos ? (zs - ATAN) : (zs + ATAN);
  end

  // Control path and output register: valids, mode_out and results clear asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0        <= 1'b0;
      vld_p1        <= '0;
      bus.out_valid <= 1'b0;
      bus.mode_out  <= 1'b0;
      bus.x_out     <= '0;
      bus.y_out     <= '0;
      bus.z_out     <= '0;
    end else if (ce) begin
      vld_p0    <= bus.in_valid;
      vld_p1[0] <= vld_p0;
      for (int i = 1; i < ITER; i++) begin
        vld_p1[i] <= vld_p1[i-1];
      end
      bus.out_valid <= vld_p1[ITER-1];
      bus.mode_out  <= mode_p1[ITER-1];
      bus.x_out     <= x_p1[ITER-1];
      bus.y_out     <= y_p1[ITER-1];
      bus.z_out     <= z_p1[ITER-1];
    end
  end

  // Data path: stage registers load on every enabled cycle, bubbles included
  always_ff @(posedge clk) begin
    if (ce) begin
      x_p0       <= x_q;
      y_p0       <= y_q;
      z_p0       <= z_q;
      mode_p0    <= bus.mode_in;
      mode_p1[0] <= mode_p0;
      for (int i = 1; i < ITER; i++) begin
        mode_p1[i] <= mode_p1[i-1];
      end
      for (int i = 0; i < ITER; i++) begin
        x_p1[i] <= x_nx[i];
        y_p1[i] <= y_nx[i];
        z_p1[i] <= z_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_cordic_pipe.sv
// Self-checking bench for cordic_pipe: directed vector table, random stream against a
// floating-point trigonometric reference, reset-in-flight and clock-enable freeze sequences.
module tb_cordic_pipe;

  localparam int  WIDTH = 32;
  localparam int  ITER  = 16;
  localparam int  FRAC  = 16;
  localparam real PI    = 3.14159265358979323846;
  localparam real SCALE = 65536.0;

  typedef struct {
    logic m;
    int   x;
    int   y;
    int   z;
    int   ex;
    int   ey;
    int   ez;
    int   tol;
  } vec_t;

  typedef struct {
    logic   m;
    longint ex;
    longint ey;
    longint ez;
  } exp_t;

  logic clk;
  logic rst_n;
  logic ce;
  int   checks;
  int   errors;
  real  kg;
  vec_t tbl [10];
  exp_t sb [$];

  cordic_if #(.WIDTH(WIDTH)) bus ();

  cordic_pipe #(.WIDTH(WIDTH), .ITER(ITER), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  // Ideal CORDIC result with gain K, from plain trigonometry
  task automatic model(input logic m, input int x, input int y, input int z, output exp_t e);
    real xr, yr, zr;
    xr = real'(x);
    yr = real'(y);
    zr = real'(z) / SCALE;
    e.m = m;
    if (!m) begin
      e.ex = longint'($rtoi(kg * (xr * $cos(zr) - yr * $sin(zr))));
      e.ey = longint'($rtoi(kg * (xr * $sin(zr) + yr * $cos(zr))));
      e.ez = 0;
    end else begin
      e.ex = longint'($rtoi(kg * $sqrt(xr * xr + yr * yr)));
      e.ey = 0;
      e.ez = longint'(z) + longint'($rtoi($atan2(yr, xr) * SCALE));
    end
  endtask

  task automatic gen_sample(input logic m, output int x, output int y, output int z);
    real a, r;
    a = ((real'($urandom_range(0, 1900000)) / 1000000.0) - 0.95) * PI;
    r = 32768.0 + real'($urandom_range(0, 32768));
    x = $rtoi(r * $cos(a));
    y = $rtoi(r * $sin(a));
    if (!m) z = int'($urandom_range(0, 411774)) - 205887;
    else    z = int'($urandom_range(0, 131072)) - 65536;
  endtask

  task automatic flush(input int n);
    repeat (n) begin
      @(negedge clk);
      ce           = 1'b1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drive(input logic v, input logic m, input int x, input int y, input int z);
    bus.in_valid = v;
    bus.mode_in  = m;
    bus.x_in     = x;
    bus.y_in     = y;
    bus.z_in     = z;
  endtask

  // One isolated sample: latency counted in enabled edges, acceptance edge included
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    flush(2);
    @(negedge clk);
    ce = 1'b1;
    drive(1'b1, v.m, v.x, v.y, v.z);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && n < 60) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk($sformatf("vec%0d_latency", idx), n, 18, 0);
    chk($sformatf("vec%0d_x", idx), bus.x_out, v.ex, v.tol);
    chk($sformatf("vec%0d_y", idx), bus.y_out, v.ey, v.tol);
    chk($sformatf("vec%0d_z", idx), bus.z_out, v.ez, v.tol);
    chk($sformatf("vec%0d_mode", idx), bus.mode_out, v.m, 0);
  endtask

  initial begin
    int   accepted, got, cyc, stale, cnt, sx, sy, sz;
    logic malt, ce_e;
    exp_t e;

    checks = 0;
    errors = 0;
    kg     = 1.0;
    for (int i = 0; i < ITER; i++) kg = kg * $sqrt(1.0 + 1.0 / (4.0 ** i));

    tbl[0] = '{1'b0,  39797,      0,       0,  65536,      0,       0,  8};
    tbl[1] = '{1'b0,  39797,      0,   51472,  46341,  46341,       0,  8};
    tbl[2] = '{1'b0,  39797,      0,  154416, -46341,  46341,       0,  8};
    tbl[3] = '{1'b1,  65536,  65536,       0, 152625,      0,   51472,  8};
    tbl[4] = '{1'b1, -65536,      0,       0, 107922,      0,  205887,  8};
    tbl[5] = '{1'b0,  39797,      0, -154416, -46341, -46341,       0, 16};
    tbl[6] = '{1'b1, -65536, -65536,       0, 152625,      0, -154416, 16};
    tbl[7] = '{1'b1,      0,  65536,       0, 107922,      0,  102944, 16};
    tbl[8] = '{1'b0,  39797,      0,  102944,      0,  65536,       0, 16};
    tbl[9] = '{1'b0,  39797,      0, -102944,      0, -65536,       0, 16};

    rst_n = 1'b1;
    ce    = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0, 0);
    chk("rst_x_out", bus.x_out, 0, 0);
    chk("rst_y_out", bus.y_out, 0, 0);
    chk("rst_z_out", bus.z_out, 0, 0);
    chk("rst_mode_out", bus.mode_out, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush(2);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Random stream: alternating modes, random in_valid and ce gaps
    flush(25);
    accepted = 0;
    got      = 0;
    cyc      = 0;
    malt     = 1'b0;
    while ((accepted < 100 || sb.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      ce = ($urandom_range(0, 3) != 0);
      gen_sample(malt, sx, sy, sz);
      drive((accepted < 100) && ($urandom_range(0, 3) != 0), malt, sx, sy, sz);
      if (bus.in_valid && ce) begin
        model(malt, sx, sy, sz, e);
        sb.push_back(e);
        accepted++;
        malt = ~malt;
      end
      @(posedge clk);
      ce_e = ce;
      #1;
      if (ce_e && bus.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_extra_valid: result with no accepted sample pending at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("rnd%0d_mode", got), bus.mode_out, e.m, 0);
          chk($sformatf("rnd%0d_x", got), bus.x_out, e.ex, 64);
          chk($sformatf("rnd%0d_y", got), bus.y_out, e.ey, 24);
          chk($sformatf("rnd%0d_z", got), bus.z_out, e.ez, 24);
          got++;
        end
      end
    end
    chk("rnd_results", got, 100, 0);
    chk("rnd_pending", sb.size(), 0, 0);

    // Reset asserted with samples in flight
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      ce = 1'b1;
      drive(1'b1, 1'b1, 65536, 65536, 0);
    end
    @(posedge clk);
    #1;
    chk("inflight_out_valid", bus.out_valid, 1, 0);
    chk("inflight_mode_out", bus.mode_out, 1, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0, 0);
    chk("midrst_x_out", bus.x_out, 0, 0);
    chk("midrst_y_out", bus.y_out, 0, 0);
    chk("midrst_z_out", bus.z_out, 0, 0);
    chk("midrst_mode_out", bus.mode_out, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (30) begin
      @(negedge clk);
      ce           = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    chk("midrst_stale_results", stale, 0, 0);
    run_vec(tbl[0], 100);

    // Clock-enable freeze with a result on the outputs and more in flight
    flush(25);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ce = 1'b1;
      drive(1'b1, 1'b0, 20000 + 1000 * k, 0, 0);
    end
    @(negedge clk);
    ce           = 1'b0;
    bus.in_valid = 1'b0;
    model(1'b0, 22000, 0, 0, e);
    chk("ce_pre_valid", bus.out_valid, 1, 0);
    chk("ce_pre_x", bus.x_out, e.ex, 8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ce_hold%0d_valid", k), bus.out_valid, 1, 0);
      chk($sformatf("ce_hold%0d_x", k), bus.x_out, e.ex, 8);
    end
    @(negedge clk);
    ce = 1'b1;
    @(posedge clk);
    #1;
    model(1'b0, 23000, 0, 0, e);
    chk("ce_resume_valid", bus.out_valid, 1, 0);
    chk("ce_resume_x", bus.x_out, e.ex, 8);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      ce           = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (bus.out_valid) cnt++;
    end
    chk("ce_remaining_results", cnt, 16, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
